// File: rtl/vga_sync_porch.sv
// vga_sync_porch: regenerates VGA HSync/VSync with porches from upstream
// active-area flags, blanks video outside the visible area and tracks
// whether the upstream frame timing is stable (o_Locked).
module vga_sync_porch #(
  parameter int unsigned VIDEO_WIDTH      = 3,
  parameter int unsigned TOTAL_COLS       = 800,
  parameter int unsigned TOTAL_ROWS       = 525,
  parameter int unsigned ACTIVE_COLS      = 640,
  parameter int unsigned ACTIVE_ROWS      = 480,
  parameter int unsigned FRONT_PORCH_HORZ = 18,
  parameter int unsigned BACK_PORCH_HORZ  = 50,
  parameter int unsigned FRONT_PORCH_VERT = 10,
  parameter int unsigned BACK_PORCH_VERT  = 33
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic                   i_HSync,
  input  logic                   i_VSync,
  input  logic [VIDEO_WIDTH-1:0] i_Red_Video,
  input  logic [VIDEO_WIDTH-1:0] i_Grn_Video,
  input  logic [VIDEO_WIDTH-1:0] i_Blu_Video,
  output logic                   o_HSync,
  output logic                   o_VSync,
  output logic [VIDEO_WIDTH-1:0] o_Red_Video,
  output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
  output logic [VIDEO_WIDTH-1:0] o_Blu_Video,
  output logic                   o_Locked
);

  localparam logic [9:0] COL_LAST  = 10'(TOTAL_COLS - 1);
  localparam logic [9:0] ROW_LAST  = 10'(TOTAL_ROWS - 1);
  localparam logic [9:0] ACT_COLS  = 10'(ACTIVE_COLS);
  localparam logic [9:0] ACT_ROWS  = 10'(ACTIVE_ROWS);
  localparam logic [9:0] HS_START  = 10'(ACTIVE_COLS + FRONT_PORCH_HORZ);
  localparam logic [9:0] HS_END    = 10'(TOTAL_COLS - BACK_PORCH_HORZ - 1);
  localparam logic [9:0] VS_START  = 10'(ACTIVE_ROWS + FRONT_PORCH_VERT);
  localparam logic [9:0] VS_END    = 10'(TOTAL_ROWS - BACK_PORCH_VERT - 1);

  // Lock confidence: number of consecutive VSync edges landing on the
  // natural counter wrap (saturating at LOCKED).
  typedef enum logic [1:0] {
    ACQ0   = 2'd0,
    ACQ1   = 2'd1,
    ACQ2   = 2'd2,
    LOCKED = 2'd3
  } lock_state_t;

  // Edge-detect registers
  logic hs_in_q, vs_in_q;
  logic hs_rise, vs_rise;

  // Stage-1 counters and video
  logic [9:0]             col_q, col_d;
  logic [9:0]             row_q, row_d;
  logic [VIDEO_WIDTH-1:0] red_q, grn_q, blu_q;

  // Lock tracking
  lock_state_t lock_q, lock_d;
  logic        locked_q, locked_d;

  // Output stage
  logic                   hsync_q, hsync_d;
  logic                   vsync_q, vsync_d;
  logic [VIDEO_WIDTH-1:0] red_out_q, red_out_d;
  logic [VIDEO_WIDTH-1:0] grn_out_q, grn_out_d;
  logic [VIDEO_WIDTH-1:0] blu_out_q, blu_out_d;

  logic at_col_end;
  logic aligned;
  logic video_en;

  assign hs_rise    = i_HSync & ~hs_in_q;
  assign vs_rise    = i_VSync & ~vs_in_q;
  assign at_col_end = (col_q == COL_LAST);
  assign aligned    = at_col_end && (row_q == ROW_LAST);

  // Register the raw sync flags for rising-edge detection
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      hs_in_q <= 1'b0;
      vs_in_q <= 1'b0;
    end else begin
      hs_in_q <= i_HSync;
      vs_in_q <= i_VSync;
    end
  end

  // Column/row next state: VSync edge realigns, otherwise free-run with wrap
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (vs_rise) begin
      col_d = '0;
      row_d = '0;
    end else if (at_col_end) begin
      col_d = '0;
      if (row_q == ROW_LAST) begin
        row_d = '0;
      end else begin
        row_d = row_q + 10'd1;
      end
    end else begin
      col_d = col_q + 10'd1;
    end
  end

  // Stage-1 counters and one-cycle video delay so video pairs with col/row
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      col_q <= '0;
      row_q <= '0;
      red_q <= '0;
      grn_q <= '0;
      blu_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      red_q <= i_Red_Video;
      grn_q <= i_Grn_Video;
      blu_q <= i_Blu_Video;
    end
  end

  // Lock state register
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      lock_q   <= ACQ0;
      locked_q <= 1'b0;
    end else begin
      lock_q   <= lock_d;
      locked_q <= locked_d;
    end
  end

  // Lock next state; a VSync edge takes priority over the other rules so a
  // misaligned VSync+HSync pair realigns to ACQ1 instead of dropping to ACQ0
  always_comb begin
    lock_d = lock_q;
    if (vs_rise) begin
      if (aligned) begin
        case (lock_q)
          ACQ0:    lock_d = ACQ1;
          ACQ1:    lock_d = ACQ2;
          ACQ2:    lock_d = LOCKED;
          default: lock_d = LOCKED;
        endcase
      end else begin
        lock_d = ACQ1;
      end
    end else if (aligned) begin
      lock_d = ACQ0;
    end else if (hs_rise && !at_col_end) begin
      lock_d = ACQ0;
    end
    locked_d = (lock_d == LOCKED);
  end

  // Output stage next state: porch-derived syncs and blanked video
  always_comb begin
    hsync_d   = 1'b1;
    vsync_d   = 1'b1;
    red_out_d = '0;
    grn_out_d = '0;
    blu_out_d = '0;
    video_en  = (col_q < ACT_COLS) && (row_q < ACT_ROWS) && locked_q;
    if ((col_q >= HS_START) && (col_q <= HS_END)) begin
      hsync_d = 1'b0;
    end
    if ((row_q >= VS_START) && (row_q <= VS_END)) begin
      vsync_d = 1'b0;
    end
    if (video_en) begin
      red_out_d = red_q;
      grn_out_d = grn_q;
      blu_out_d = blu_q;
    end
  end

  // Output registers driving the VGA pins
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      red_out_q <= '0;
      grn_out_q <= '0;
      blu_out_q <= '0;
    end else begin
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      red_out_q <= red_out_d;
      grn_out_q <= grn_out_d;
      blu_out_q <= blu_out_d;
    end
  end

  assign o_HSync     = hsync_q;
  assign o_VSync     = vsync_q;
  assign o_Red_Video = red_out_q;
  assign o_Grn_Video = grn_out_q;
  assign o_Blu_Video = blu_out_q;
  assign o_Locked    = locked_q;

endmodule

// File: tb/tb_vga_sync_porch.sv
// Randomized bench for vga_sync_porch against a frame-level reference model,
// using a reduced frame geometry so several lock cycles fit in a short run.
module tb_vga_sync_porch;

  localparam int VW  = 3;
  localparam int TC  = 20;
  localparam int TR  = 12;
  localparam int AC  = 12;
  localparam int AR  = 8;
  localparam int FPH = 2;
  localparam int BPH = 3;
  localparam int FPV = 1;
  localparam int BPV = 2;
  localparam int NCYC = 9600;

  logic          clk = 1'b0;
  logic          rst;
  logic          hs_i, vs_i;
  logic [VW-1:0] r_i, g_i, b_i;
  logic          hs_o, vs_o, lk_o;
  logic [VW-1:0] r_o, g_o, b_o;

  int checks = 0;
  int failures = 0;

  vga_sync_porch #(
    .VIDEO_WIDTH(VW), .TOTAL_COLS(TC), .TOTAL_ROWS(TR),
    .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
    .FRONT_PORCH_HORZ(FPH), .BACK_PORCH_HORZ(BPH),
    .FRONT_PORCH_VERT(FPV), .BACK_PORCH_VERT(BPV)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_HSync(hs_i), .i_VSync(vs_i),
    .i_Red_Video(r_i), .i_Grn_Video(g_i), .i_Blu_Video(b_i),
    .o_HSync(hs_o), .o_VSync(vs_o),
    .o_Red_Video(r_o), .o_Grn_Video(g_o), .o_Blu_Video(b_o),
    .o_Locked(lk_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: position of the last pixel accepted, confidence count,
  // the pixel awaiting output, and the expected pin values.
  int m_col, m_row, m_conf;
  bit m_hp, m_vp, m_lk;
  int m_r, m_g, m_b;
  int e_hs, e_vs, e_r, e_g, e_b, e_lk;

  task automatic model_reset();
    m_col = 0; m_row = 0; m_conf = 0;
    m_hp = 0; m_vp = 0; m_lk = 0;
    m_r = 0; m_g = 0; m_b = 0;
    e_hs = 1; e_vs = 1; e_r = 0; e_g = 0; e_b = 0; e_lk = 0;
  endtask

  task automatic model_step();
    bit vr, hr, at_wrap, vis;
    if (rst) begin
      model_reset();
      return;
    end
    vr = vs_i && !m_vp;
    hr = hs_i && !m_hp;
    at_wrap = (m_col == TC-1) && (m_row == TR-1);
    // pins reflect the pixel accepted one clock earlier
    e_hs = (m_col >= AC+FPH && m_col <= TC-BPH-1) ? 0 : 1;
    e_vs = (m_row >= AR+FPV && m_row <= TR-BPV-1) ? 0 : 1;
    vis  = (m_col < AC) && (m_row < AR) && m_lk;
    e_r = vis ? m_r : 0;
    e_g = vis ? m_g : 0;
    e_b = vis ? m_b : 0;
    if (vr) m_conf = at_wrap ? ((m_conf < 3) ? m_conf + 1 : 3) : 1;
    else if (at_wrap) m_conf = 0;
    else if (hr && m_col != TC-1) m_conf = 0;
    m_lk = (m_conf == 3);
    e_lk = m_lk ? 1 : 0;
    if (vr) begin
      m_col = 0; m_row = 0;
    end else begin
      m_col = m_col + 1;
      if (m_col == TC) begin
        m_col = 0;
        m_row = (m_row + 1) % TR;
      end
    end
    m_r = r_i; m_g = g_i; m_b = b_i;
    m_hp = hs_i; m_vp = vs_i;
  endtask

  task automatic check_pins();
    check("hsync", 32'(hs_o), 32'(e_hs));
    check("vsync", 32'(vs_o), 32'(e_vs));
    check("red",   32'(r_o),  32'(e_r));
    check("grn",   32'(g_o),  32'(e_g));
    check("blu",   32'(b_o),  32'(e_b));
    check("locked", 32'(lk_o), 32'(e_lk));
  endtask

  // Upstream timing generator state and per-frame perturbations
  int  u_col, u_row, frames, frame_cyc, reset_at, g_row, g_col, pert;
  bit  stall_pend, supp_v, glitch_on;
  int  lock_seen = 0;

  task automatic drive_inputs();
    hs_i = (u_col < AC) && !(glitch_on && u_row == g_row && u_col == g_col);
    vs_i = (u_row < AR) && !supp_v;
    r_i = VW'($urandom);
    g_i = VW'($urandom);
    b_i = VW'($urandom);
  endtask

  initial begin
    rst = 1'b1;
    hs_i = 1'b0; vs_i = 1'b0; r_i = '0; g_i = '0; b_i = '0;
    model_reset();
    stall_pend = 0; supp_v = 0; glitch_on = 0;
    frames = 0; frame_cyc = 0; reset_at = 0; g_row = 0; g_col = 0;
    repeat (2) @(posedge clk);
    #1;
    check_pins();
    u_col = $urandom_range(0, TC-1);
    u_row = $urandom_range(0, TR-1);
    drive_inputs();
    rst = 1'b0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      model_step();
      check_pins();
      if (lk_o) lock_seen++;
      if (rst) rst = 1'b0;

      if (stall_pend && u_col == TC-1 && u_row == TR-1) begin
        stall_pend = 0;
      end else begin
        u_col++;
        if (u_col == TC) begin
          u_col = 0;
          u_row = (u_row + 1) % TR;
        end
      end
      frame_cyc++;
      if (u_col == 0 && u_row == 0) begin
        frames++;
        frame_cyc = 0;
        supp_v = 0; glitch_on = 0; reset_at = 0;
        pert = (frames > 4) ? $urandom_range(0, 9) : 0;
        case (pert)
          6: stall_pend = 1;
          7: supp_v = 1;
          8: begin
            glitch_on = 1;
            g_row = $urandom_range(0, AR-1);
            g_col = $urandom_range(1, AC-2);
          end
          9: reset_at = $urandom_range(1, TC*TR-2);
          default: ;
        endcase
      end
      drive_inputs();
      if (reset_at != 0 && frame_cyc == reset_at) begin
        reset_at = 0;
        rst = 1'b1;
        #1;
        model_reset();
        check("async_rst_hsync", 32'(hs_o), 32'd1);
        check("async_rst_vsync", 32'(vs_o), 32'd1);
        check("async_rst_red",   32'(r_o),  32'd0);
        check("async_rst_grn",   32'(g_o),  32'd0);
        check("async_rst_blu",   32'(b_o),  32'd0);
        check("async_rst_locked", 32'(lk_o), 32'd0);
      end
    end
    check("lock_seen", 32'(lock_seen > 0), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
